// File: rtl/mem_ctrl.sv
// mem_ctrl: bridges 32-bit CPU instruction/data ports onto a byte-wide big-endian external memory
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rom_ce_i,
    input  logic [31:0] rom_addr_i,
    output logic [31:0] rom_data_o,
    input  logic        ram_ce_i,
    input  logic        ram_we_i,
    input  logic [31:0] ram_addr_i,
    input  logic [3:0]  ram_sel_i,
    input  logic [31:0] ram_data_i,
    output logic [31:0] ram_data_o,
    output logic        stall_o,
    output logic [31:0] ext_addr_o,
    output logic [7:0]  ext_data_o,
    input  logic [7:0]  ext_data_i,
    output logic        ext_we_o
);
    typedef enum logic [2:0] {IDLE, D_RUN, D_WAIT, I_RUN, I_WAIT, DONE} state_t;
    state_t state, nxt;
    logic [1:0] cnt, idx;
    logic [31:0] base, wd_l;
    logic [3:0] sel_l;
    logic [23:0] rd_buf;
    logic we_l, ld_ram, ld_rom, run, wt, wr;
    assign run = state == D_RUN || state == I_RUN;
    assign wt = state == D_WAIT || state == I_WAIT;
    assign wr = state == D_RUN && we_l;
    assign idx = ~cnt;
    assign ext_addr_o = (run || wt) ? ((base & ~32'd3) | {30'd0, wt ? 2'b11 : cnt}) : 32'd0;
    assign ext_we_o = wr & sel_l[idx];
    assign ext_data_o = wr ? wd_l[{idx, 3'b000} +: 8] : 8'd0;
    assign stall_o = !rst && (ram_ce_i || rom_ce_i) && state != DONE;
    // next-state: data access first, optional fetch afterwards, one DONE cycle to release the pipeline
    always_comb begin
        nxt = state;
        ld_ram = 1'b0;
        ld_rom = 1'b0;
        case (state)
            IDLE: begin
                if (ram_ce_i) begin
                    nxt = D_RUN;
                    ld_ram = 1'b1;
                end else if (rom_ce_i) begin
                    nxt = I_RUN;
                    ld_rom = 1'b1;
                end
            end
            D_RUN: begin
                if (cnt == 2'd3) begin
                    if (!we_l) nxt = D_WAIT;
                    else if (rom_ce_i) begin
                        nxt = I_RUN;
                        ld_rom = 1'b1;
                    end else nxt = DONE;
                end
            end
            D_WAIT: begin
                if (rom_ce_i) begin
                    nxt = I_RUN;
                    ld_rom = 1'b1;
                end else nxt = DONE;
            end
            I_RUN: nxt = cnt == 2'd3 ? I_WAIT : I_RUN;
            I_WAIT: nxt = DONE;
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
    // state, latched request and read assembly; bytes arrive one cycle after their address
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= 2'd0;
            base <= 32'd0;
            we_l <= 1'b0;
            sel_l <= 4'd0;
            wd_l <= 32'd0;
            rd_buf <= 24'd0;
            rom_data_o <= 32'd0;
            ram_data_o <= 32'd0;
        end else begin
            state <= nxt;
            cnt <= run ? cnt + 2'd1 : 2'd0;
            if (ld_ram) begin
                base <= ram_addr_i;
                we_l <= ram_we_i;
                sel_l <= ram_sel_i;
                wd_l <= ram_data_i;
            end
            if (ld_rom) base <= rom_addr_i;
            if (run) rd_buf <= {rd_buf[15:0], ext_data_i};
            if (state == D_WAIT) ram_data_o <= {rd_buf, ext_data_i};
            if (state == I_WAIT) rom_data_o <= {rd_buf, ext_data_i};
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: transaction-level model of mem_ctrl checked every cycle, plus directed literal checks
module tb_mem_ctrl;
    logic clk = 0, rst = 1;
    logic rom_ce_i = 0, ram_ce_i = 0, ram_we_i = 0;
    logic [31:0] rom_addr_i = 0, ram_addr_i = 0, ram_data_i = 0;
    logic [3:0] ram_sel_i = 0;
    logic [31:0] rom_data_o, ram_data_o, ext_addr_o;
    logic [7:0] ext_data_o, ext_data_i = 0;
    logic stall_o, ext_we_o;
    int total = 0, bad = 0, n;
    bit started = 0;
    logic [7:0] mem [0:65535];
    logic [31:0] exp_ram = 0, exp_rom = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [7:0]  wd;
        logic        done, decide, ur, uf;
        logic [31:0] val;
    } rec_t;
    rec_t q[$];

    mem_ctrl dut (.clk(clk), .rst(rst), .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i), .rom_data_o(rom_data_o),
        .ram_ce_i(ram_ce_i), .ram_we_i(ram_we_i), .ram_addr_i(ram_addr_i), .ram_sel_i(ram_sel_i),
        .ram_data_i(ram_data_i), .ram_data_o(ram_data_o), .stall_o(stall_o), .ext_addr_o(ext_addr_o),
        .ext_data_o(ext_data_o), .ext_data_i(ext_data_i), .ext_we_o(ext_we_o));

    always #5 clk = ~clk;

    // byte-wide external memory with one cycle read latency
    always @(posedge clk) begin
        if (ext_we_o) mem[ext_addr_o[15:0]] <= ext_data_o;
        ext_data_i <= mem[ext_addr_o[15:0]];
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] word(logic [31:0] a);
        logic [15:0] b = {a[15:2], 2'b00};
        return {mem[b], mem[b + 16'd1], mem[b + 16'd2], mem[b + 16'd3]};
    endfunction

    function automatic void add(logic [31:0] a, logic we, logic [7:0] wd, logic dn, logic dec, logic ur, logic uf, logic [31:0] v);
        rec_t r;
        r.addr = a; r.we = we; r.wd = wd; r.done = dn; r.decide = dec; r.ur = ur; r.uf = uf; r.val = v;
        q.push_back(r);
    endfunction

    // a word access is four byte slots at consecutive addresses, high byte first; reads add one wait slot
    function automatic void push_data(logic [31:0] a, logic w, logic [3:0] s, logic [31:0] d);
        for (int i = 0; i < 4; i++)
            add({a[31:2], 2'(i)}, w & s[3 - i], w ? d[8 * (3 - i) +: 8] : 8'd0, 0, w && i == 3, 0, 0, 0);
        if (!w) add({a[31:2], 2'b11}, 0, 0, 0, 1, 1, 0, word(a));
    endfunction

    function automatic void push_fetch(logic [31:0] a);
        for (int i = 0; i < 4; i++) add({a[31:2], 2'(i)}, 0, 0, 0, 0, 0, 0, 0);
        add({a[31:2], 2'b11}, 0, 0, 0, 0, 0, 1, word(a));
        add(0, 0, 0, 1, 0, 0, 0, 0);
    endfunction

    // model: one record per expected cycle, checked at every falling edge
    always @(negedge clk) if (started) begin
        rec_t r;
        if (q.size() == 0 && !rst && (ram_ce_i || rom_ce_i)) begin
            add(0, 0, 0, 0, 0, 0, 0, 0);
            if (ram_ce_i) push_data(ram_addr_i, ram_we_i, ram_sel_i, ram_data_i);
            else push_fetch(rom_addr_i);
        end
        if (q.size() > 0) r = q.pop_front();
        else r = '{32'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
        chk("stall", {31'd0, stall_o}, {31'd0, (ram_ce_i | rom_ce_i) & !r.done & !rst});
        chk("ext_addr", ext_addr_o, r.addr);
        chk("ext_we", {31'd0, ext_we_o}, {31'd0, r.we});
        chk("ext_data", {24'd0, ext_data_o}, {24'd0, r.wd});
        chk("ram_data", ram_data_o, exp_ram);
        chk("rom_data", rom_data_o, exp_rom);
        if (r.decide) begin
            if (rom_ce_i) push_fetch(rom_addr_i);
            else add(0, 0, 0, 1, 0, 0, 0, 0);
        end
        if (r.ur) exp_ram = r.val;
        if (r.uf) exp_rom = r.val;
        if (rst) begin
            q.delete();
            exp_ram = 0;
            exp_rom = 0;
        end
    end

    task automatic step(int k);
        repeat (k) begin
            @(posedge clk);
            #2;
        end
    endtask

    // counts cycles with stall high, ending in the first stall-low cycle
    task automatic wait_done(output int cyc);
        cyc = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!stall_o || cyc > 40) break;
            cyc++;
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        {mem[16'h100], mem[16'h101], mem[16'h102], mem[16'h103]} = 32'h34020020;
        {mem[16'h2000], mem[16'h2001], mem[16'h2002], mem[16'h2003]} = 32'h01020304;
        {mem[16'h40], mem[16'h41], mem[16'h42], mem[16'h43]} = 32'h11223344;
        {mem[16'h0], mem[16'h1], mem[16'h2], mem[16'h3]} = 32'hDEADBEEF;
        @(posedge clk);
        started = 1;
        #2;
        rom_ce_i = 1;
        step(1);
        chk("stall_in_reset", {31'd0, stall_o}, 0);
        chk("rom_rst", rom_data_o, 0);
        chk("ram_rst", ram_data_o, 0);
        rst = 0;
        rom_ce_i = 0;
        step(10);
        chk("idle_addr", ext_addr_o, 0);
        rom_ce_i = 1; rom_addr_i = 32'h100;
        wait_done(n);
        chk("fetch_lat", n, 6);
        chk("fetch_word", rom_data_o, 32'h34020020);
        rom_ce_i = 0;
        step(2);
        ram_ce_i = 1; ram_we_i = 1; ram_addr_i = 32'h2002; ram_sel_i = 4'b0110; ram_data_i = 32'hAABBCCDD;
        wait_done(n);
        chk("write_lat", n, 5);
        ram_ce_i = 0;
        step(2);
        chk("wr_2000", {24'd0, mem[16'h2000]}, 32'h01);
        chk("wr_2001", {24'd0, mem[16'h2001]}, 32'hBB);
        chk("wr_2002", {24'd0, mem[16'h2002]}, 32'hCC);
        chk("wr_2003", {24'd0, mem[16'h2003]}, 32'h04);
        ram_ce_i = 1; ram_we_i = 0; ram_addr_i = 32'h41; rom_ce_i = 1; rom_addr_i = 32'h2;
        wait_done(n);
        chk("rd_fetch_lat", n, 11);
        chk("rd_word", ram_data_o, 32'h11223344);
        chk("rd_fetch_word", rom_data_o, 32'hDEADBEEF);
        ram_ce_i = 0; rom_ce_i = 0;
        step(2);
        ram_ce_i = 1; ram_we_i = 1; ram_addr_i = 32'h3000; ram_sel_i = 4'b1111; ram_data_i = 32'hCAFEF00D;
        rom_ce_i = 1; rom_addr_i = 32'h100;
        wait_done(n);
        chk("wr_fetch_lat", n, 10);
        chk("wr_fetch_word", rom_data_o, 32'h34020020);
        chk("wr_keeps_ram", ram_data_o, 32'h11223344);
        ram_ce_i = 0; rom_ce_i = 0;
        step(2);
        chk("wr_3000", word(32'h3000), 32'hCAFEF00D);
        ram_ce_i = 1; ram_we_i = 1; ram_addr_i = 32'h2100; ram_sel_i = 4'b1001; ram_data_i = 32'h55667788;
        step(2);
        ram_addr_i = 32'h2200; ram_sel_i = 4'b1111;
        wait_done(n);
        chk("midchg_lat", n, 3);
        ram_ce_i = 0;
        step(2);
        chk("midchg_2100", word(32'h2100), 32'h55000088);
        chk("midchg_2200", word(32'h2200), 32'h0);
        ram_ce_i = 1; ram_we_i = 1; ram_addr_i = 32'h2300; ram_sel_i = 4'b1111; ram_data_i = 32'hA1B2C3D4;
        step(2);
        rst = 1; ram_ce_i = 0;
        step(1);
        rst = 0;
        chk("rst_we", {31'd0, ext_we_o}, 0);
        chk("rst_addr", ext_addr_o, 0);
        chk("rst_rom", rom_data_o, 0);
        chk("rst_ram", ram_data_o, 0);
        step(4);
        chk("rst_2300", word(32'h2300), 32'hA1B2_0000);
        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
